// File: rtl/wdt_pkg.sv
// Shared watchdog definitions: FSM state encoding, default timing constants
// and small helpers, reused by the watchdog timer and its reset controller.
package wdt_pkg;

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned TCNT_W = 8;

  localparam int unsigned DEF_GRACE_CYCLES   = 1024;
  localparam int unsigned DEF_RST_CYCLES     = 16;
  localparam int unsigned DEF_HOLDOFF_CYCLES = 64;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WARN    = 2'd1,
    ST_RESET   = 2'd2,
    ST_HOLDOFF = 2'd3
  } wdt_state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [TCNT_W-1:0] sat_inc(input logic [TCNT_W-1:0] v);
    return (v == {TCNT_W{1'b1}}) ? v : v + TCNT_W'(1);
  endfunction

endpackage

// File: rtl/wdt_downcnt.sv
// Loadable 16-bit down-counter shared by the timed watchdog states.
// Load wins over decrement; decrement stops at zero.
module wdt_downcnt
  import wdt_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_ONE;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/wdt_reset_ctrl.sv
// Watchdog escalation controller: IDLE -> WARN (irq) -> RESET (sys_rst) ->
// HOLDOFF -> IDLE, with a sticky cause flag and saturating timeout count.
module wdt_reset_ctrl
  import wdt_pkg::*;
#(
  parameter int unsigned GRACE_CYCLES   = DEF_GRACE_CYCLES,
  parameter int unsigned RST_CYCLES     = DEF_RST_CYCLES,
  parameter int unsigned HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wdt_pulse,
  input  logic              kick,
  input  logic              clr_cause,
  output logic              irq,
  output logic              sys_rst,
  output logic              wdt_clr,
  output logic              cause_wdt,
  output logic [TCNT_W-1:0] timeout_cnt,
  output logic [1:0]        state
);

  // Counter holds "cycles left minus one", so zero marks the last cycle of a phase.
  localparam logic [CNT_W-1:0] GRACE_LD   = CNT_W'(GRACE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RST_LD     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLDOFF_LD = CNT_W'(HOLDOFF_CYCLES - 1);

  wdt_state_e        r_state;
  logic              r_irq;
  logic              r_sys_rst;
  logic              r_wdt_clr;
  logic              r_cause_wdt;
  logic [TCNT_W-1:0] r_timeout_cnt;

  logic              w_zero;
  logic              w_load;
  logic              w_dec;
  logic [CNT_W-1:0]  w_load_val;
  logic              w_enter_reset;

  // Kick beats both a second pulse and grace expiry while warning.
  assign w_enter_reset = (r_state == ST_WARN) && !kick && (wdt_pulse || w_zero);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no branch can
    // leave one unassigned and infer a latch.
    w_load     = 1'b0;
    w_dec      = 1'b0;
    w_load_val = '0;
    case (r_state)
      ST_IDLE: begin
        if (wdt_pulse) begin
          w_load     = 1'b1;
          w_load_val = GRACE_LD;
        end
      end
      ST_WARN: begin
        if (w_enter_reset) begin
          w_load     = 1'b1;
          w_load_val = RST_LD;
        end else if (!kick) begin
          w_dec = 1'b1;
        end
      end
      ST_RESET: begin
        if (w_zero) begin
          w_load     = 1'b1;
          w_load_val = HOLDOFF_LD;
        end else begin
          w_dec = 1'b1;
        end
      end
      ST_HOLDOFF: begin
        w_dec = 1'b1;
      end
    endcase
  end

  wdt_downcnt u_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_dec      (w_dec),
    .o_zero     (w_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_irq         <= 1'b0;
      r_sys_rst     <= 1'b0;
      r_wdt_clr     <= 1'b0;
      r_cause_wdt   <= 1'b0;
      r_timeout_cnt <= '0;
    end else begin
      r_wdt_clr <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (wdt_pulse) begin
            r_state <= ST_WARN;
            r_irq   <= 1'b1;
          end else if (kick) begin
            r_wdt_clr <= 1'b1;
          end
        end
        ST_WARN: begin
          if (kick) begin
            r_state   <= ST_IDLE;
            r_irq     <= 1'b0;
            r_wdt_clr <= 1'b1;
          end else if (w_enter_reset) begin
            r_state   <= ST_RESET;
            r_irq     <= 1'b0;
            r_sys_rst <= 1'b1;
            r_wdt_clr <= 1'b1;
          end
        end
        ST_RESET: begin
          if (w_zero) begin
            r_state   <= ST_HOLDOFF;
            r_sys_rst <= 1'b0;
          end
        end
        ST_HOLDOFF: begin
          if (kick) r_wdt_clr <= 1'b1;
          if (w_zero) r_state <= ST_IDLE;
        end
      endcase

      // A reset entry outranks a coincident clear: the event is still recorded.
      if (w_enter_reset) begin
        r_cause_wdt   <= 1'b1;
        r_timeout_cnt <= clr_cause ? TCNT_W'(1) : sat_inc(r_timeout_cnt);
      end else if (clr_cause) begin
        r_cause_wdt   <= 1'b0;
        r_timeout_cnt <= '0;
      end
    end
  end

  assign irq         = r_irq;
  assign sys_rst     = r_sys_rst;
  assign wdt_clr     = r_wdt_clr;
  assign cause_wdt   = r_cause_wdt;
  assign timeout_cnt = r_timeout_cnt;
  assign state       = r_state;

endmodule

// File: tb/tb_wdt_reset_ctrl.sv
// Self-checking bench for wdt_reset_ctrl: directed scenarios with literal
// expectations plus randomized stimulus compared every cycle to a phase/deadline model.
module tb_wdt_reset_ctrl;

  localparam int GRACE = 8;
  localparam int RSTC  = 4;
  localparam int HOLD  = 6;

  localparam logic [1:0] P_IDLE  = 2'd0;
  localparam logic [1:0] P_WARN  = 2'd1;
  localparam logic [1:0] P_RESET = 2'd2;
  localparam logic [1:0] P_HOLD  = 2'd3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wdt_pulse = 1'b0;
  logic       kick = 1'b0;
  logic       clr_cause = 1'b0;
  logic       irq, sys_rst, wdt_clr, cause_wdt;
  logic [7:0] timeout_cnt;
  logic [1:0] state;

  int n_checks = 0;
  int n_pass   = 0;

  wdt_reset_ctrl #(
    .GRACE_CYCLES   (GRACE),
    .RST_CYCLES     (RSTC),
    .HOLDOFF_CYCLES (HOLD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wdt_pulse   (wdt_pulse),
    .kick        (kick),
    .clr_cause   (clr_cause),
    .irq         (irq),
    .sys_rst     (sys_rst),
    .wdt_clr     (wdt_clr),
    .cause_wdt   (cause_wdt),
    .timeout_cnt (timeout_cnt),
    .state       (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0d required %0d at t=%0t", name, act, exp, $time);
  endtask

  // Model: current phase plus the absolute cycle index on which it ends.
  typedef struct packed {
    logic [1:0]  phase;
    logic [31:0] phase_end;
    logic        clr;
    logic        cause;
    logic [7:0]  tcnt;
  } model_t;

  model_t      m = '0;
  logic        m_valid = 1'b0;
  int unsigned cyc = 0;

  function automatic model_t model_next(input model_t cur, input int unsigned c,
                                        input logic r, input logic p,
                                        input logic k, input logic cl);
    model_t nx;
    logic   expire;
    logic   enter;
    nx     = cur;
    nx.clr = 1'b0;
    enter  = 1'b0;
    expire = (c == cur.phase_end);
    if (r) return '0;
    case (cur.phase)
      P_IDLE: begin
        if (p) begin
          nx.phase     = P_WARN;
          nx.phase_end = c + GRACE;
        end else if (k) begin
          nx.clr = 1'b1;
        end
      end
      P_WARN: begin
        if (k) begin
          nx.phase = P_IDLE;
          nx.clr   = 1'b1;
        end else if (p || expire) begin
          nx.phase     = P_RESET;
          nx.phase_end = c + RSTC;
          nx.clr       = 1'b1;
          enter        = 1'b1;
        end
      end
      P_RESET: begin
        if (expire) begin
          nx.phase     = P_HOLD;
          nx.phase_end = c + HOLD;
        end
      end
      default: begin
        if (k) nx.clr = 1'b1;
        if (expire) nx.phase = P_IDLE;
      end
    endcase
    if (enter) begin
      nx.cause = 1'b1;
      nx.tcnt  = cl ? 8'd1 : ((cur.tcnt == 8'd255) ? 8'd255 : cur.tcnt + 8'd1);
    end else if (cl) begin
      nx.cause = 1'b0;
      nx.tcnt  = 8'd0;
    end
    return nx;
  endfunction

  always @(posedge clk) begin
    m   <= model_next(m, cyc, rst, wdt_pulse, kick, clr_cause);
    cyc <= cyc + 1;
    if (rst) m_valid <= 1'b1;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("cmp_state",   state,       m.phase);
      check("cmp_irq",     irq,         m.phase == P_WARN);
      check("cmp_sys_rst", sys_rst,     m.phase == P_RESET);
      check("cmp_wdt_clr", wdt_clr,     m.clr);
      check("cmp_cause",   cause_wdt,   m.cause);
      check("cmp_tcnt",    timeout_cnt, m.tcnt);
    end
  end

  // Drive one cycle of inputs; returns just after the edge that sampled them.
  task automatic step(input logic p, input logic k, input logic c, input logic r);
    wdt_pulse = p;
    kick      = k;
    clr_cause = c;
    rst       = r;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 50 && state != P_IDLE; i++) step(0, 0, 0, 0);
    check(tag, state, P_IDLE);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  int   n_irq, n_srst, n_rst_st, n_hold, first_srst;
  logic seen_srst;

  initial begin
    repeat (3) step(0, 0, 0, 1);
    check("rst_state",   state,       0);
    check("rst_irq",     irq,         0);
    check("rst_sys_rst", sys_rst,     0);
    check("rst_wdt_clr", wdt_clr,     0);
    check("rst_cause",   cause_wdt,   0);
    check("rst_tcnt",    timeout_cnt, 0);
    step(0, 0, 0, 0);

    // Full escalation with no service.
    step(1, 0, 0, 0);
    n_irq = 0; n_srst = 0; n_hold = 0; first_srst = -1;
    for (int i = 0; i < 40 && state != P_IDLE; i++) begin
      if (sys_rst && first_srst < 0) first_srst = i;
      n_irq  += int'(irq);
      n_srst += int'(sys_rst);
      n_hold += int'(state == P_HOLD);
      step(0, 0, 0, 0);
    end
    check("A_irq_cycles",  n_irq,       8);
    check("A_srst_rise",   first_srst,  8);
    check("A_srst_cycles", n_srst,      4);
    check("A_hold_cycles", n_hold,      6);
    check("A_cause",       cause_wdt,   1);
    check("A_tcnt",        timeout_cnt, 1);

    // Clear cause, then kick on WARN cycle 3.
    step(0, 0, 1, 0);
    check("E_clr_cause", cause_wdt,   0);
    check("E_clr_tcnt",  timeout_cnt, 0);
    step(1, 0, 0, 0);
    seen_srst = sys_rst;
    repeat (2) begin
      step(0, 0, 0, 0);
      seen_srst |= sys_rst;
    end
    step(0, 1, 0, 0);
    check("B_irq_low",   irq,     0);
    check("B_wdt_clr",   wdt_clr, 1);
    check("B_state",     state,   0);
    step(0, 0, 0, 0);
    check("B_wdt_clr_1cyc", wdt_clr, 0);
    repeat (12) begin
      seen_srst |= sys_rst;
      step(0, 0, 0, 0);
    end
    check("B_no_srst", seen_srst,   0);
    check("B_tcnt",    timeout_cnt, 0);

    // Second pulse on WARN cycle 2 escalates at once.
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    check("C_srst_now",  sys_rst, 1);
    check("C_state_rst", state,   2);
    wait_idle("C_back_idle");
    check("C_tcnt", timeout_cnt, 1);

    // Kick on the final grace cycle still rescues.
    step(1, 0, 0, 0);
    repeat (7) step(0, 0, 0, 0);
    check("C_last_warn", irq, 1);
    step(0, 1, 0, 0);
    check("C_kick_state", state,   0);
    check("C_kick_clr",   wdt_clr, 1);
    seen_srst = 1'b0;
    repeat (10) begin
      step(0, 0, 0, 0);
      seen_srst |= sys_rst;
    end
    check("C_no_srst", seen_srst,   0);
    check("C_tcnt2",   timeout_cnt, 1);

    // Pulses during RESET and HOLDOFF are ignored.
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check("D_in_reset", state, 2);
    n_rst_st = 0; n_hold = 0;
    for (int i = 0; i < 40 && state != P_IDLE; i++) begin
      n_rst_st += int'(state == P_RESET);
      n_hold   += int'(state == P_HOLD);
      step(1, 0, 0, 0);
    end
    check("D_idle",        state,    0);
    check("D_reset_len",   n_rst_st, 4);
    check("D_holdoff_len", n_hold,   6);
    check("D_tcnt",        timeout_cnt, 2);
    step(1, 0, 0, 0);
    check("D_warn_again", state, 1);
    step(0, 1, 0, 0);

    // Saturation of the timeout count.
    step(0, 0, 1, 0);
    for (int n = 0; n < 256; n++) begin
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      wait_idle("E_sat_idle");
    end
    check("E_sat_tcnt",  timeout_cnt, 255);
    check("E_sat_cause", cause_wdt,   1);
    step(0, 0, 1, 0);
    check("E_clr2_cause", cause_wdt,   0);
    check("E_clr2_tcnt",  timeout_cnt, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    wait_idle("E_pre_idle");
    check("E_pre_tcnt", timeout_cnt, 1);
    step(1, 0, 0, 0);
    step(1, 0, 1, 0);
    check("E_entry_state", state,       2);
    check("E_entry_cause", cause_wdt,   1);
    check("E_entry_tcnt",  timeout_cnt, 1);
    wait_idle("E_post_idle");

    // rst on RESET cycle 2 aborts the pulse.
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    check("F_reset_c2", sys_rst, 1);
    step(0, 0, 0, 1);
    check("F_sys_rst", sys_rst,     0);
    check("F_state",   state,       0);
    check("F_irq",     irq,         0);
    check("F_wdt_clr", wdt_clr,     0);
    check("F_cause",   cause_wdt,   0);
    check("F_tcnt",    timeout_cnt, 0);
    step(0, 0, 0, 0);

    // rst mid-WARN.
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    check("F_warn_abort_irq",   irq,   0);
    check("F_warn_abort_state", state, 0);
    step(0, 0, 0, 0);

    // Randomized traffic, checked every cycle by the model compare.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 11) == 0,
           $urandom_range(0, 13) == 0,
           $urandom_range(0, 49) == 0,
           $urandom_range(0, 399) == 0);
    end
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wdt_reset_ctrl.md
WDT_RESET_CTRL -- requirements
Module: wdt_reset_ctrl

Interface
REQ-001 The module SHALL have parameter GRACE_CYCLES, default 1024: cycles in WARN before escalating to reset; legal range 1..65535.
REQ-002 The module SHALL have parameter RST_CYCLES, default 16: width in cycles of the system reset pulse; legal range 1..65535.
REQ-003 The module SHALL have parameter HOLDOFF_CYCLES, default 64: cycles after reset release during which wdt_pulse is ignored; legal range 1..65535.
REQ-004 The module SHALL have port clk, input, 1: clock.
REQ-005 The module SHALL have port rst, input, 1: reset; synchronous, active-high.
REQ-006 The module SHALL have port wdt_pulse, input, 1: single-cycle timeout event from the 32-bit watchdog timer.
REQ-007 The module SHALL have port kick, input, 1: software service strobe, level-sampled each cycle.
REQ-008 The module SHALL have port clr_cause, input, 1: clears the sticky cause flag and the timeout count.
REQ-009 The module SHALL have port irq, output, 1: early-warning interrupt, high while in WARN.
REQ-010 The module SHALL have port sys_rst, output, 1: system reset request, high while in RESET.
REQ-011 The module SHALL have port wdt_clr, output, 1: one-cycle pulse that clears the upstream watchdog counter.
REQ-012 The module SHALL have port cause_wdt, output, 1: sticky flag, set when a watchdog reset has occurred.
REQ-013 The module SHALL have port timeout_cnt, output, 8: saturating count of watchdog resets.
REQ-014 The module SHALL have port state, output, 2: current FSM state encoding.

Function
REQ-015 The FSM SHALL have four states: IDLE=0, WARN=1, RESET=2, HOLDOFF=3.
REQ-016 The FSM SHALL use a single 16-bit down-counter, cnt, shared across the timed states.
REQ-017 All outputs SHALL be registered, with no combinational path from any input to any output.
REQ-018 IDLE: on wdt_pulse=1, the FSM SHALL go to WARN, load cnt=GRACE_CYCLES-1, and assert irq starting the next cycle.
REQ-019 IDLE: when kick=1 and wdt_pulse=1 in the same cycle, wdt_pulse SHALL win, so the FSM enters WARN.
REQ-020 IDLE: kick=1 alone SHALL pulse wdt_clr for one cycle and leave the state unchanged.
REQ-021 WARN: on kick=1, the FSM SHALL go to IDLE, deassert irq, and pulse wdt_clr for one cycle; kick SHALL have priority over grace expiry in the same cycle.
REQ-022 WARN: on wdt_pulse=1 without kick, the FSM SHALL escalate to RESET immediately.
REQ-023 WARN: when cnt==0 and there is no kick, the FSM SHALL go to RESET; otherwise cnt SHALL decrement.
REQ-024 WARN latency SHALL be exactly GRACE_CYCLES cycles from wdt_pulse to sys_rst rising, absent kick or a second pulse.
REQ-025 On entry to RESET, the module SHALL assert sys_rst, load cnt=RST_CYCLES-1, set cause_wdt=1, increment timeout_cnt (saturating at 255), and pulse wdt_clr.
REQ-026 RESET SHALL hold sys_rst high for exactly RST_CYCLES cycles, then go to HOLDOFF with cnt=HOLDOFF_CYCLES-1.
REQ-027 RESET SHALL ignore kick and wdt_pulse.
REQ-028 HOLDOFF SHALL ignore wdt_pulse and SHALL honour kick (wdt_clr pulse).
REQ-029 When cnt==0 in HOLDOFF, the FSM SHALL go to IDLE.
REQ-030 clr_cause SHALL zero cause_wdt and timeout_cnt in any state.
REQ-031 When clr_cause coincides with entry to RESET, the set and increment SHALL win, giving cause_wdt=1 and timeout_cnt=1.
REQ-032 The module SHALL NOT be reset by its own sys_rst; only rst SHALL reset it.

Reset
REQ-033 On rst=1, the module SHALL reset to state=IDLE, cnt=0, irq=0, sys_rst=0, wdt_clr=0, cause_wdt=0 and timeout_cnt=0.
REQ-034 rst asserted mid-WARN or mid-RESET SHALL abort the sequence and drop sys_rst the next cycle.

Structure
REQ-035 State encodings, and the default GRACE/RST/HOLDOFF constants, SHALL be placed in a shared package, wdt_pkg, reused by the watchdog timer.
REQ-036 A single sub-module, wdt_downcnt, SHALL provide the 16-bit loadable down-counter with load, dec and zero flag.

Verification
REQ-037 The bench SHALL cover: wdt_pulse in IDLE, no kick, GRACE_CYCLES=8, RST_CYCLES=4 -> irq high for 8 cycles, then sys_rst high for exactly 4 cycles, cause_wdt=1, timeout_cnt=1.
REQ-038 The bench SHALL cover: wdt_pulse, then kick on WARN cycle 3 -> irq low next cycle, wdt_clr one-cycle pulse, sys_rst never asserted, timeout_cnt=0.
REQ-039 The bench SHALL cover: a second wdt_pulse on WARN cycle 2 -> sys_rst rises next cycle; kick coinciding with cnt==0 -> return to IDLE, no reset.
REQ-040 The bench SHALL cover: wdt_pulse during RESET and during HOLDOFF (HOLDOFF_CYCLES=6) -> ignored; wdt_pulse one cycle after return to IDLE -> WARN.
REQ-041 The bench SHALL cover: 256 forced resets -> timeout_cnt saturates at 255; clr_cause -> cause_wdt=0 and timeout_cnt=0; clr_cause on the RESET-entry cycle -> cause_wdt=1 and timeout_cnt=1.
REQ-042 The bench SHALL cover: rst pulsed on RESET cycle 2 -> sys_rst=0 next cycle, state=IDLE, all outputs 0.
